// File: rtl/im_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// im_port_arbiter_if
//   Bundle of every signal around the instruction-memory port arbiter:
//   the fetch requester, the program loader and the memory port itself.
//
//   Handshake: a requester raises req with its address/data and holds them
//   stable; the access is accepted at the rising edge that ends a cycle in
//   which req && gnt. gnt is combinational and never waits on the next edge.
//   Read data comes back as a one-cycle rvalid pulse two cycles after
//   acceptance; rdata holds its last value while rvalid is low.
//
//   Modports:
//     slave  - the arbiter: consumes requests and im_rdata, drives grants,
//              responses and the memory port.
//     master - the surrounding system (requesters + memory).
// ---------------------------------------------------------------------------
interface im_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  // fetch side (read-only)
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_flush;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  // loader side (read/write)
  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_lock;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  // memory port
  logic              im_read;
  logic              im_write;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic [DATA_W-1:0] im_rdata;

  modport slave (
    input  f_req, f_addr, f_flush,
    output f_gnt, f_rvalid, f_rdata,
    input  l_req, l_we, l_addr, l_wdata, l_lock,
    output l_gnt, l_rvalid, l_rdata,
    output im_read, im_write, im_addr, im_wdata,
    input  im_rdata
  );

  modport master (
    output f_req, f_addr, f_flush,
    input  f_gnt, f_rvalid, f_rdata,
    output l_req, l_we, l_addr, l_wdata, l_lock,
    input  l_gnt, l_rvalid, l_rdata,
    input  im_read, im_write, im_addr, im_wdata,
    output im_rdata
  );
endinterface

// File: rtl/im_port_arbiter.sv
// ---------------------------------------------------------------------------
// im_port_arbiter
//   Shares the single instruction-memory port between instruction fetch
//   (read-only) and the program loader (read/write). At most one access is
//   granted per cycle; the winner is registered onto the memory port (issue
//   stage) and the read data is registered back to its owner (response
//   stage), giving a fixed read latency of two cycles.
//
//   Arbitration: the only eligible requester wins; on a tie a locked loader
//   wins while its burst count is below MAX_BURST, otherwise round-robin
//   against last_win. A fetch flush blocks the fetch grant for that cycle and
//   kills the fetch response already sitting in the issue stage.
//
//   Ports:
//     clk  - clock, all state on the rising edge
//     rst  - asynchronous, active-low reset
//     bus  - im_port_arbiter_if.slave (fetch, loader and memory signals)
// ---------------------------------------------------------------------------
module im_port_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                rst,
  im_port_arbiter_if.slave    bus
);

  typedef enum logic {
    OWN_FETCH  = 1'b0,
    OWN_LOADER = 1'b1
  } owner_e;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  // arbitration state
  owner_e      last_win;
  logic [7:0]  burst_cnt;

  // arbitration decode
  logic        f_elig;
  logic        l_elig;
  logic        lock_wins;
  logic        f_gnt;
  logic        l_gnt;

  // issue stage
  logic              iss_read;
  logic              iss_write;
  logic [ADDR_W-1:0] iss_addr;
  logic [DATA_W-1:0] iss_wdata;
  logic              iss_f_vld;   // issued read belongs to fetch (flushable)
  logic              iss_l_rd;    // issued read belongs to loader

  // response stage
  logic              rsp_f_vld;
  logic [DATA_W-1:0] rsp_f_data;
  logic              rsp_l_vld;
  logic [DATA_W-1:0] rsp_l_data;

  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    f_elig    = bus.f_req && !bus.f_flush;
    l_elig    = bus.l_req;
    lock_wins = bus.l_lock && (burst_cnt < BURST_MAX);
    // Grants look at rst directly so they drop the instant reset asserts.
    if (rst) begin
      if (f_elig && l_elig) begin
        if (lock_wins || (last_win == OWN_FETCH)) l_gnt = 1'b1;
        else                                      f_gnt = 1'b1;
      end else begin
        f_gnt = f_elig;
        l_gnt = l_elig;
      end
    end
  end

  // Arbitration state: last winner and loader burst counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win  <= OWN_LOADER;
      burst_cnt <= 8'd0;
    end else begin
      if (f_gnt)      last_win <= OWN_FETCH;
      else if (l_gnt) last_win <= OWN_LOADER;

      // Any fetch grant or a dropped lock ends the burst; otherwise a locked
      // loader grant counts up and sticks at the limit.
      if (f_gnt || !bus.l_lock)                burst_cnt <= 8'd0;
      else if (l_gnt && (burst_cnt < BURST_MAX)) burst_cnt <= burst_cnt + 8'd1;
    end
  end

  // Issue stage: register the winning request onto the memory port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_read  <= 1'b0;
      iss_write <= 1'b0;
      iss_addr  <= '0;
      iss_wdata <= '0;
      iss_f_vld <= 1'b0;
      iss_l_rd  <= 1'b0;
    end else begin
      iss_read  <= f_gnt || (l_gnt && !bus.l_we);
      iss_write <= l_gnt && bus.l_we;
      iss_f_vld <= f_gnt;
      iss_l_rd  <= l_gnt && !bus.l_we;
      if (f_gnt) begin
        iss_addr <= bus.f_addr;
      end else if (l_gnt) begin
        iss_addr  <= bus.l_addr;
        iss_wdata <= bus.l_wdata;
      end
    end
  end

  // Response stage: capture memory data with its owner tag. A flush kills the
  // fetch read currently in the issue stage; the memory still performs the
  // read but the data is neither flagged nor latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_f_vld  <= 1'b0;
      rsp_f_data <= '0;
      rsp_l_vld  <= 1'b0;
      rsp_l_data <= '0;
    end else begin
      rsp_f_vld <= iss_f_vld && !bus.f_flush;
      rsp_l_vld <= iss_l_rd;
      if (iss_f_vld && !bus.f_flush) rsp_f_data <= bus.im_rdata;
      if (iss_l_rd)                  rsp_l_data <= bus.im_rdata;
    end
  end

  assign bus.f_gnt    = f_gnt;
  assign bus.l_gnt    = l_gnt;
  assign bus.im_read  = iss_read;
  assign bus.im_write = iss_write;
  assign bus.im_addr  = iss_addr;
  assign bus.im_wdata = iss_wdata;
  assign bus.f_rvalid = rsp_f_vld;
  assign bus.f_rdata  = rsp_f_data;
  assign bus.l_rvalid = rsp_l_vld;
  assign bus.l_rdata  = rsp_l_data;

endmodule

// File: tb/tb_im_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_im_port_arbiter
//   Directed bench for im_port_arbiter. A behavioural memory (combinational
//   read, write on the clock edge) sits on the memory port. Inputs change
//   1 time unit after the rising edge; outputs are sampled on the falling
//   edge. Memory word i starts as 32'hC0DE0000 | i, except word 4.
// ---------------------------------------------------------------------------
module tb_im_port_arbiter;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  im_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  im_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem [1024];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[4] = 32'h12345678;
  end

  always @(posedge clk) begin
    if (bus.im_write) mem[bus.im_addr] <= bus.im_wdata;
  end

  assign bus.im_rdata = bus.im_read ? mem[bus.im_addr] : '0;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " f_gnt"},    32'(bus.f_gnt),    32'd0);
    check({tag, " l_gnt"},    32'(bus.l_gnt),    32'd0);
    check({tag, " im_read"},  32'(bus.im_read),  32'd0);
    check({tag, " im_write"}, 32'(bus.im_write), 32'd0);
    check({tag, " im_addr"},  32'(bus.im_addr),  32'd0);
    check({tag, " im_wdata"}, bus.im_wdata,      32'd0);
    check({tag, " f_rvalid"}, 32'(bus.f_rvalid), 32'd0);
    check({tag, " f_rdata"},  bus.f_rdata,       32'd0);
    check({tag, " l_rvalid"}, 32'(bus.l_rvalid), 32'd0);
    check({tag, " l_rdata"},  bus.l_rdata,       32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.f_req   = 1'b0;
    bus.f_addr  = '0;
    bus.f_flush = 1'b0;
    bus.l_req   = 1'b0;
    bus.l_we    = 1'b0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
    bus.l_lock  = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              fr;
    logic [ADDR_W-1:0] fa;
    logic              ff;
    logic              lr;
    logic              lwe;
    logic [ADDR_W-1:0] la;
    logic [DATA_W-1:0] lwd;
    logic              ll;
    logic              fg;
    logic              lg;
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] ia;
    logic              frv;
    logic [DATA_W-1:0] frd;
    logic              lrv;
    logic [DATA_W-1:0] lrd;
  } vec_t;

  function automatic vec_t mk(
    input logic fr, input logic [ADDR_W-1:0] fa, input logic ff,
    input logic lr, input logic lwe, input logic [ADDR_W-1:0] la,
    input logic [DATA_W-1:0] lwd, input logic ll,
    input logic fg, input logic lg, input logic rd, input logic wr,
    input logic [ADDR_W-1:0] ia, input logic frv, input logic [DATA_W-1:0] frd,
    input logic lrv, input logic [DATA_W-1:0] lrd);
    vec_t v;
    v.fr = fr; v.fa = fa; v.ff = ff; v.lr = lr; v.lwe = lwe; v.la = la;
    v.lwd = lwd; v.ll = ll; v.fg = fg; v.lg = lg; v.rd = rd; v.wr = wr;
    v.ia = ia; v.frv = frv; v.frd = frd; v.lrv = lrv; v.lrd = lrd;
    return v;
  endfunction

  vec_t vecs [16];

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit exp_f, exp_l, g_f, g_l;

    //            fr fa      ff lr we la      lwd           ll | fg lg rd wr ia      frv frd           lrv lrd
    // round robin, F first after reset
    vecs[0]  = mk(1, 10'h010, 0, 1, 0, 10'h020, 32'h0,        0,  1, 0, 0, 0, 10'h000, 0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(1, 10'h010, 0, 1, 0, 10'h020, 32'h0,        0,  0, 1, 1, 0, 10'h010, 0, 32'h0,        0, 32'h0);
    vecs[2]  = mk(1, 10'h010, 0, 1, 0, 10'h020, 32'h0,        0,  1, 0, 1, 0, 10'h020, 1, 32'hC0DE0010, 0, 32'h0);
    vecs[3]  = mk(1, 10'h010, 0, 1, 0, 10'h020, 32'h0,        0,  0, 1, 1, 0, 10'h010, 0, 32'h0,        1, 32'hC0DE0020);
    vecs[4]  = mk(1, 10'h010, 0, 1, 0, 10'h020, 32'h0,        0,  1, 0, 1, 0, 10'h020, 1, 32'hC0DE0010, 0, 32'h0);
    vecs[5]  = mk(1, 10'h010, 0, 1, 0, 10'h020, 32'h0,        0,  0, 1, 1, 0, 10'h010, 0, 32'h0,        1, 32'hC0DE0020);
    vecs[6]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 32'h0,        0,  0, 0, 1, 0, 10'h020, 1, 32'hC0DE0010, 0, 32'h0);
    vecs[7]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 32'h0,        0,  0, 0, 0, 0, 10'h000, 0, 32'h0,        1, 32'hC0DE0020);
    // single fetch of word 4
    vecs[8]  = mk(1, 10'h004, 0, 0, 0, 10'h000, 32'h0,        0,  1, 0, 0, 0, 10'h000, 0, 32'h0,        0, 32'h0);
    vecs[9]  = mk(0, 10'h000, 0, 0, 0, 10'h000, 32'h0,        0,  0, 0, 1, 0, 10'h004, 0, 32'h0,        0, 32'h0);
    vecs[10] = mk(0, 10'h000, 0, 0, 0, 10'h000, 32'h0,        0,  0, 0, 0, 0, 10'h000, 1, 32'h12345678, 0, 32'h0);
    // loader write to the top word, then fetch it back
    vecs[11] = mk(0, 10'h000, 0, 1, 1, 10'h3FF, 32'hDEADBEEF, 0,  0, 1, 0, 0, 10'h000, 0, 32'h0,        0, 32'h0);
    vecs[12] = mk(0, 10'h000, 0, 0, 0, 10'h000, 32'h0,        0,  0, 0, 0, 1, 10'h3FF, 0, 32'h0,        0, 32'h0);
    vecs[13] = mk(1, 10'h3FF, 0, 0, 0, 10'h000, 32'h0,        0,  1, 0, 0, 0, 10'h000, 0, 32'h0,        0, 32'h0);
    vecs[14] = mk(0, 10'h000, 0, 0, 0, 10'h000, 32'h0,        0,  0, 0, 1, 0, 10'h3FF, 0, 32'h0,        0, 32'h0);
    vecs[15] = mk(0, 10'h000, 0, 0, 0, 10'h000, 32'h0,        0,  0, 0, 0, 0, 10'h000, 1, 32'hDEADBEEF, 0, 32'h0);

    // ---- reset with both requesters active: grants must stay low ----
    drive_idle();
    rst = 1'b0;
    bus.f_req = 1'b1;
    bus.l_req = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    drive_idle();
    next_cycle();
    rst = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      bus.f_req   = vecs[i].fr;
      bus.f_addr  = vecs[i].fa;
      bus.f_flush = vecs[i].ff;
      bus.l_req   = vecs[i].lr;
      bus.l_we    = vecs[i].lwe;
      bus.l_addr  = vecs[i].la;
      bus.l_wdata = vecs[i].lwd;
      bus.l_lock  = vecs[i].ll;
      @(negedge clk);
      check($sformatf("vec%0d f_gnt", i),    32'(bus.f_gnt),    32'(vecs[i].fg));
      check($sformatf("vec%0d l_gnt", i),    32'(bus.l_gnt),    32'(vecs[i].lg));
      check($sformatf("vec%0d im_read", i),  32'(bus.im_read),  32'(vecs[i].rd));
      check($sformatf("vec%0d im_write", i), 32'(bus.im_write), 32'(vecs[i].wr));
      check($sformatf("vec%0d f_rvalid", i), 32'(bus.f_rvalid), 32'(vecs[i].frv));
      check($sformatf("vec%0d l_rvalid", i), 32'(bus.l_rvalid), 32'(vecs[i].lrv));
      if (vecs[i].rd || vecs[i].wr)
        check($sformatf("vec%0d im_addr", i), 32'(bus.im_addr), 32'(vecs[i].ia));
      if (vecs[i].frv) check($sformatf("vec%0d f_rdata", i), bus.f_rdata, vecs[i].frd);
      if (vecs[i].lrv) check($sformatf("vec%0d l_rdata", i), bus.l_rdata, vecs[i].lrd);
    end

    // ---- burst lock: 8 locked loader writes, one fetch, loader again ----
    next_cycle();
    drive_idle();
    bus.f_req   = 1'b1;
    bus.f_addr  = 10'h008;
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_lock  = 1'b1;
    bus.l_addr  = 10'h100;
    bus.l_wdata = 32'hB0000000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_f = (k == 8);
      exp_l = (k != 8);
      check($sformatf("burst%0d f_gnt", k),    32'(bus.f_gnt),    32'(exp_f));
      check($sformatf("burst%0d l_gnt", k),    32'(bus.l_gnt),    32'(exp_l));
      check($sformatf("burst%0d im_write", k), 32'(bus.im_write), 32'((k >= 1) && (k <= 8)));
      check($sformatf("burst%0d im_read", k),  32'(bus.im_read),  32'(k == 9));
      g_f = bus.f_gnt;
      g_l = bus.l_gnt;
      next_cycle();
      if (g_l) begin
        bus.l_addr  = bus.l_addr + 10'd1;
        bus.l_wdata = bus.l_wdata + 32'd1;
      end
      if (g_f) bus.f_addr = 10'h009;
    end
    drive_idle();
    repeat (3) next_cycle();
    check("burst last write data", mem[10'h107], 32'hB0000007);
    check("burst first write data", mem[10'h100], 32'hB0000000);

    // ---- flush: fetch accepted at N, flush at N+1 with a loader read ----
    bus.f_req  = 1'b1;
    bus.f_addr = 10'h030;
    @(negedge clk);
    check("flush N f_gnt", 32'(bus.f_gnt), 32'd1);
    next_cycle();
    bus.f_addr  = 10'h031;
    bus.f_flush = 1'b1;
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b0;
    bus.l_addr  = 10'h040;
    @(negedge clk);
    check("flush N+1 f_gnt", 32'(bus.f_gnt), 32'd0);
    check("flush N+1 l_gnt", 32'(bus.l_gnt), 32'd1);
    check("flush N+1 im_addr", 32'(bus.im_addr), 32'h030);
    next_cycle();
    drive_idle();
    @(negedge clk);
    check("flush N+2 f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check("flush N+2 im_read",  32'(bus.im_read),  32'd1);
    check("flush N+2 im_addr",  32'(bus.im_addr),  32'h040);
    next_cycle();
    @(negedge clk);
    check("flush N+3 f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check("flush N+3 l_rvalid", 32'(bus.l_rvalid), 32'd1);
    check("flush N+3 l_rdata",  bus.l_rdata,       32'hC0DE0040);
    check("flush N+3 f_rdata",  bus.f_rdata,       32'hC0DE0008);
    next_cycle();
    @(negedge clk);
    check("flush N+4 f_rvalid", 32'(bus.f_rvalid), 32'd0);
    check("flush N+4 l_rvalid", 32'(bus.l_rvalid), 32'd0);

    // ---- reset asserted mid-burst ----
    next_cycle();
    bus.f_req   = 1'b1;
    bus.f_addr  = 10'h050;
    bus.l_req   = 1'b1;
    bus.l_we    = 1'b1;
    bus.l_lock  = 1'b1;
    bus.l_addr  = 10'h200;
    bus.l_wdata = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    #2;
    check("pre-reset im_write", 32'(bus.im_write), 32'd1);
    rst = 1'b0;
    #1;
    check_all_zero("mid-burst reset");
    bus.l_lock = 1'b0;
    bus.l_we   = 1'b0;
    repeat (2) next_cycle();
    check("in-reset f_gnt", 32'(bus.f_gnt), 32'd0);
    check("in-reset l_gnt", 32'(bus.l_gnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset tie f_gnt", 32'(bus.f_gnt), 32'd1);
    check("post-reset tie l_gnt", 32'(bus.l_gnt), 32'd0);
    next_cycle();
    drive_idle();
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
